// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the six-digit clock core.
//   state_e     : set-mode FSM states (RUN, SET_HOUR, SET_MIN)
//   FIELD_*     : set_field output encodings
//   *_MAX       : BCD wrap limits for seconds, minutes and hours
//   BLINK_*     : blink_mask patterns for the field being edited
//   field_of()  : maps an FSM state to its set_field encoding
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_e;

  localparam logic [1:0] FIELD_RUN      = 2'd0;
  localparam logic [1:0] FIELD_SET_HOUR = 2'd1;
  localparam logic [1:0] FIELD_SET_MIN  = 2'd2;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam logic [5:0] BLINK_HOUR = 6'b110000;
  localparam logic [5:0] BLINK_MIN  = 6'b001100;

  function automatic logic [1:0] field_of(input state_e s);
    logic [1:0] f;
    f = FIELD_RUN;
    case (s)
      ST_SET_HOUR: f = FIELD_SET_HOUR;
      ST_SET_MIN:  f = FIELD_SET_MIN;
      default:     f = FIELD_RUN;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: two-digit BCD counter that wraps between 00 and MAX_BCD.
//   clk, rstn : clock, asynchronous active-low reset (value -> 00)
//   inc       : step up one, wrapping MAX_BCD -> 00
//   dec       : step down one, wrapping 00 -> MAX_BCD
//   clr       : force 00 (highest priority)
//   value     : {tens, ones} BCD
//   carry     : high in the cycle an inc wraps MAX_BCD -> 00
module bcd_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = SEC_MAX
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_q, value_d;
  logic       at_max;

  assign at_max = (value_q == MAX_BCD);
  assign carry  = inc & at_max & ~clr;
  assign value  = value_q;

  // Digits are stepped directly in BCD; the ones digit borrows or carries
  // into the tens digit, and the whole pair wraps at the field limit.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 8'h00;
    end else if (inc) begin
      if (at_max)
        value_d = 8'h00;
      else if (value_q[3:0] == 4'd9)
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      else
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
    end else if (dec) begin
      if (value_q == 8'h00)
        value_d = MAX_BCD;
      else if (value_q[3:0] == 4'd0)
        value_d = {value_q[7:4] - 4'd1, 4'd9};
      else
        value_d = {value_q[7:4], value_q[3:0] - 4'd1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) value_q <= 8'h00;
    else       value_q <= value_d;
  end

endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: timekeeping core for the six-digit 7-segment clock.
// Prescaler, HH:MM:SS BCD counters, set-mode FSM, blink mask and chime.
// Build option: define CLOCK_12H_EN for 12-hour display (hour_bcd 01..12
// plus pm flag); otherwise hour_bcd is 00..23 and pm is tied low.
//   clk, rstn         : clock, asynchronous active-low reset
//   key_mode_p        : advance RUN -> SET_HOUR -> SET_MIN -> RUN
//   key_inc_p/dec_p   : step the selected field (SET states only)
//   sec/min/hour_bcd  : BCD time digits
//   pm                : afternoon flag (12-hour build only)
//   set_field         : 0 RUN, 1 SET_HOUR, 2 SET_MIN
//   blink_mask        : 1 blanks a digit, bit0 sec ones .. bit5 hour tens
//   tick_1hz          : one-cycle pulse with each new running second
//   chime             : high for CHIME_SEC seconds from the top of the hour
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int CHIME_SEC = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_mode_p,
  input  logic       key_inc_p,
  input  logic       key_dec_p,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       pm,
  output logic [1:0] set_field,
  output logic [5:0] blink_mask,
  output logic       tick_1hz,
  output logic       chime
);

  localparam int               PRE_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_HALF   = PRE_W'(CLK_HZ / 2);
  localparam logic [5:0]       CHIME_LOAD = 6'(CHIME_SEC);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [5:0]       blink_q, blink_d;
  logic             chime_q, chime_d;
  logic [5:0]       chime_cnt_q, chime_cnt_d;

  logic       inc_ok, dec_ok;
  logic       in_run, in_set_hour, in_set_min;
  logic       sec_step, leave_set, enter_set, new_hour;
  logic [7:0] sec_val, min_val, hour_val;
  logic       sec_carry, min_carry, hour_wrap_unused;

  // A step key counts only when it is alone: mode overrides it and
  // inc+dec together cancel.
  assign inc_ok = key_inc_p & ~key_dec_p & ~key_mode_p;
  assign dec_ok = key_dec_p & ~key_inc_p & ~key_mode_p;

  assign in_run      = (state_q == ST_RUN);
  assign in_set_hour = (state_q == ST_SET_HOUR);
  assign in_set_min  = (state_q == ST_SET_MIN);

  assign sec_step  = in_run & (pre_q == PRE_MAX);
  assign leave_set = in_set_min & key_mode_p;
  assign enter_set = in_run & key_mode_p;
  // Seconds and minutes both wrapping on a running step means MM:SS -> 00:00.
  assign new_hour  = sec_step & sec_carry & min_carry;

  bcd_counter #(.MAX_BCD(SEC_MAX)) u_sec (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (sec_step),
    .dec   (1'b0),
    .clr   (leave_set),
    .value (sec_val),
    .carry (sec_carry)
  );

  bcd_counter #(.MAX_BCD(MIN_MAX)) u_min (
    .clk   (clk),
    .rstn  (rstn),
    .inc   ((sec_step & sec_carry) | (in_set_min & inc_ok)),
    .dec   (in_set_min & dec_ok),
    .clr   (1'b0),
    .value (min_val),
    .carry (min_carry)
  );

  bcd_counter #(.MAX_BCD(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (new_hour | (in_set_hour & inc_ok)),
    .dec   (in_set_hour & dec_ok),
    .clr   (1'b0),
    .value (hour_val),
    .carry (hour_wrap_unused)
  );

  always_comb begin
    state_d = state_q;
    if (key_mode_p) begin
      case (state_q)
        ST_RUN:      state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  // The prescaler free-runs in every state so the blink phase keeps
  // going while editing; leaving SET_MIN restarts the second cleanly.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (leave_set || pre_q == PRE_MAX)
      pre_d = '0;
  end

  always_comb begin
    tick_d  = sec_step;
    blink_d = 6'b000000;
    if (pre_q >= PRE_HALF) begin
      if (in_set_hour)     blink_d = BLINK_HOUR;
      else if (in_set_min) blink_d = BLINK_MIN;
    end
  end

  // The chime counts remaining seconds; the clearing happens on the
  // CHIME_SEC-th second step after the one that started it, so it stays
  // high for exactly CHIME_SEC seconds.
  always_comb begin
    chime_d     = chime_q;
    chime_cnt_d = chime_cnt_q;
    if (enter_set) begin
      chime_d     = 1'b0;
      chime_cnt_d = 6'd0;
    end else if (new_hour) begin
      chime_d     = 1'b1;
      chime_cnt_d = CHIME_LOAD;
    end else if (sec_step && chime_q) begin
      if (chime_cnt_q <= 6'd1) begin
        chime_d     = 1'b0;
        chime_cnt_d = 6'd0;
      end else begin
        chime_cnt_d = chime_cnt_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      pre_q       <= '0;
      tick_q      <= 1'b0;
      blink_q     <= 6'b000000;
      chime_q     <= 1'b0;
      chime_cnt_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      tick_q      <= tick_d;
      blink_q     <= blink_d;
      chime_q     <= chime_d;
      chime_cnt_q <= chime_cnt_d;
    end
  end

  assign sec_bcd    = sec_val;
  assign min_bcd    = min_val;
  assign set_field  = field_of(state_q);
  assign blink_mask = blink_q;
  assign tick_1hz   = tick_q;
  assign chime      = chime_q;

`ifdef CLOCK_12H_EN
  // 24h -> 12h done digit-wise: 13..19 drop the tens and subtract 2 from
  // the ones; 20..21 become 08..09; 22..23 become 10..11.
  always_comb begin
    hour_bcd = hour_val;
    pm       = 1'b0;
    if (hour_val == 8'h00) begin
      hour_bcd = 8'h12;
    end else if (hour_val == 8'h12) begin
      pm = 1'b1;
    end else if (hour_val[7:4] == 4'd1 && hour_val[3:0] >= 4'd3) begin
      hour_bcd = {4'd0, hour_val[3:0] - 4'd2};
      pm       = 1'b1;
    end else if (hour_val[7:4] == 4'd2) begin
      pm = 1'b1;
      if (hour_val[3:0] < 4'd2)
        hour_bcd = {4'd0, hour_val[3:0] + 4'd8};
      else
        hour_bcd = {4'd1, hour_val[3:0] - 4'd2};
    end
  end
`else
  assign hour_bcd = hour_val;
  assign pm       = 1'b0;
`endif

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Parametrised timekeeping core for the six-digit 7-segment clock. It replaces the fixed s/m/h timer chain and key mux with one synchronous block:
- internal 1 Hz prescaler
- HH:MM:SS BCD counters
- three-state set FSM with inc/dec of the selected field
- digit-blink mask for the selected field
- timed top-of-hour chime

Inputs are debounced one-cycle key pulses; outputs feed the decoders and scan unit directly.

Parameters:
CLK_HZ, 50_000_000, clk frequency; prescaler terminal count is CLK_HZ-1, width $clog2(CLK_HZ).
CHIME_SEC, 4, chime duration in seconds (1..59).

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
key_mode_p  input  1  debounced one-cycle pulse: advance set FSM
key_inc_p  input  1  debounced one-cycle pulse: increment selected field
key_dec_p  input  1  debounced one-cycle pulse: decrement selected field
sec_bcd  output  8  seconds, {tens[7:4], ones[3:0]}, 00..59
min_bcd  output  8  minutes, BCD, 00..59
hour_bcd  output  8  hours, BCD, 00..23 (01..12 with CLOCK_12H_EN)
pm  output  1  PM flag (CLOCK_12H_EN only; constant 0 otherwise)
set_field  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN
blink_mask  output  6  1=blank digit; bit0=sec ones .. bit5=hour tens
tick_1hz  output  1  one-cycle pulse, coincident with each new running second value
chime  output  1  top-of-hour indicator

Behaviour:
- Async reset (rstn=0): all counters 00:00:00, prescaler 0, state RUN. All outputs 0.
- FSM: RUN -mode-> SET_HOUR -mode-> SET_MIN -mode-> RUN.
  - Entry into SET_HOUR clears chime.
  - SET_MIN->RUN clears seconds to 00 and prescaler to 0 on the same edge.
- RUN:
  - Prescaler counts every clk.
  - At prescaler==CLK_HZ-1: prescaler->0, sec increments on that edge, and tick_1hz is high the following cycle.
  - Carry chain: 59s->00 increments min; 59m->00 increments hour; 23->00 wraps. 23:59:59 -> 00:00:00 in one edge.
- SET states:
  - Prescaler keeps running (drives blink); seconds frozen; no carries.
  - inc/dec modify only the selected field, with wrap: hour 23<->00, min 59<->00.
  - No carry into other fields.
- Key priority:
  - mode and inc/dec in the same cycle: mode wins; inc/dec is dropped.
  - inc and dec together: both ignored.
  - inc/dec in RUN: ignored.
- blink_mask:
  - In SET_HOUR, bits[5:4]=1 while prescaler>=CLK_HZ/2; in SET_MIN, bits[3:2] likewise.
  - Otherwise 0.
  - Registered, one cycle behind the prescaler.
- chime:
  - Set on the edge where RUN time becomes MM:SS=00:00 (including rollover from 23:59:59).
  - Held for CHIME_SEC ticks, then cleared.
  - A new hour during chime restarts the count.
- Reset mid-operation: immediate return to reset state regardless of FSM state.
- Counters are held as BCD digit pairs (ones 0..9, tens limited per field); never binary-converted.

Optional Feature:
CLOCK_12H_EN:
- Defined: internal hour stays 0..23, and the outputs are converted combinationally from the registered value:
  - 0 -> hour_bcd 12, pm=0
  - 1..11 -> same value, pm=0
  - 12 -> 12, pm=1
  - 13..23 -> h-12, pm=1
  - SET_HOUR inc/dec still steps the internal 0..23 value.
- Undefined: hour_bcd = internal 00..23 and pm tied 0.

Decomposition:
- Package clock_pkg: state enum (ST_RUN, ST_SET_HOUR, ST_SET_MIN), set_field encodings, BCD limit constants (SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23).
- Sub-module bcd_counter:
  - Parameter MAX_BCD.
  - Inputs: inc, dec, clr.
  - Outputs: 8-bit value and carry (carry on wrap during inc).
  - Instantiated three times.

Test Plan:
- CLK_HZ=4, reset then 240 clk -> sec_bcd=8'h59 after 236 clk and 8'h00 at 240, min_bcd=8'h01; tick_1hz pulses every 4 clk.
- Preload 23:59:59 via SET (hour 23, min 59, then run 59 s) -> next tick gives 00:00:00 and chime=1 for exactly CHIME_SEC*CLK_HZ clk.
- mode, then 3x dec -> hour 00->23->22->21; 24x inc from 00 -> 00 with min unchanged.
- SET_MIN, inc+dec same cycle -> min unchanged; mode+inc same cycle -> state RUN, min unchanged, sec=00, prescaler=0.
- SET_HOUR blink -> blink_mask=6'b110000 for cycles 2..3 of each 4-clk second, else 0; RUN -> always 0.
- Assert rstn=0 during SET_MIN -> all outputs 0 immediately; with CLOCK_12H_EN, hour 0 -> hour_bcd=8'h12, pm=0; hour 13 -> 8'h01, pm=1.
